// File: rtl/mem_write_scoreboard.sv
// rtl/mem_write_scoreboard.sv - store-sequence checker for the MIPS core data-memory write bus
// Optional MWSB_STAMP_EN adds a per-entry match-time stamp RAM with stamp_idx/stamp ports.
module mem_write_scoreboard #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int WE_W   = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 10,
  parameter int STRICT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [AW-1:0]            load_addr,
  input  logic [DW-1:0]            load_data,
  input  logic [$clog2(DEPTH):0]   num_expect,
  input  logic [CNT_W-1:0]         timeout_lim,
  input  logic                     start,
  input  logic [WE_W-1:0]          memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     tout,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [AW-1:0]            fail_addr,
  output logic [DW-1:0]            fail_data
`ifdef MWSB_STAMP_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] stamp_idx,
  output logic [CNT_W-1:0]         stamp
`endif
);

  localparam int IW       = $clog2(DEPTH);
  localparam int NW       = IW + 1;
  localparam bit STRICT_B = (STRICT != 0);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NW-1:0]     r_num;
  logic [CNT_W-1:0]  r_lim;
  logic [NW-1:0]     r_match;
  logic [CNT_W-1:0]  r_cycle;
  logic [AW-1:0]     r_fail_addr;
  logic [DW-1:0]     r_fail_data;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_tout;

  // Table has no reset: its contents are only meaningful after loading in IDLE.
  logic [AW-1:0]     r_tab_addr [DEPTH];
  logic [DW-1:0]     r_tab_data [DEPTH];

  logic [IW-1:0]     w_ptr;
  logic              w_in_run;
  logic              w_store;
  logic              w_match;
  logic              w_hit;
  logic              w_miss;
  logic              w_last;
  logic              w_to;
  logic [NW-1:0]     w_num_clamp;

  assign w_ptr       = r_match[IW-1:0];
  assign w_in_run    = (r_state == S_RUN);
  assign w_store     = |memwrite;
  assign w_match     = (dataadr == r_tab_addr[w_ptr]) && (writedata == r_tab_data[w_ptr]);
  assign w_hit       = w_in_run && w_store && w_match;
  assign w_miss      = w_in_run && w_store && !w_match && STRICT_B;
  assign w_last      = ((r_match + NW'(1)) == r_num);
  assign w_to        = w_in_run && (r_lim != '0) && (r_cycle == (r_lim - CNT_W'(1)));
  assign w_num_clamp = (num_expect > NW'(DEPTH)) ? NW'(DEPTH) : num_expect;

  always_ff @(posedge clk) begin
    if (load_en && (r_state == S_IDLE)) begin
      r_tab_addr[load_idx] <= load_addr;
      r_tab_data[load_idx] <= load_data;
    end
  end

  // Terminal events outrank the timeout that may fall on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = (w_num_clamp == '0) ? S_PASS : S_RUN;
    else if (w_hit && w_last)
      w_state_nxt = S_PASS;
    else if (w_miss)
      w_state_nxt = S_FAIL;
    else if (w_to)
      w_state_nxt = S_TOUT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_lim       <= '0;
      r_match     <= '0;
      r_cycle     <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tout      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) || (w_state_nxt == S_TOUT);
      r_pass  <= (w_state_nxt == S_PASS);
      r_fail  <= (w_state_nxt == S_FAIL);
      r_tout  <= (w_state_nxt == S_TOUT);
      if (start) begin
        r_num       <= w_num_clamp;
        r_lim       <= timeout_lim;
        r_match     <= '0;
        r_cycle     <= '0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_in_run) begin
        if (r_cycle != '1)
          r_cycle <= r_cycle + CNT_W'(1);
        if (w_hit)
          r_match <= r_match + NW'(1);
        if (w_miss) begin
          r_fail_addr <= dataadr;
          r_fail_data <= writedata;
        end
      end
    end
  end

`ifdef MWSB_STAMP_EN
  logic [CNT_W-1:0] r_stamp [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stamp[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < DEPTH; i++) r_stamp[i] <= '0;
    end else if (w_hit) begin
      r_stamp[w_ptr] <= r_cycle;
    end
  end

  assign stamp = r_stamp[stamp_idx];
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign tout      = r_tout;
  assign match_cnt = r_match;
  assign cycle_cnt = r_cycle;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// tb/tb_mem_write_scoreboard.sv - scoreboard bench for mem_write_scoreboard (STRICT=0 and STRICT=1 instances)
module tb_mem_write_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [2:0]  load_idx;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [3:0]  num_expect;
  logic [9:0]  timeout_lim;
  logic        start;
  logic [1:0]  memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
`ifdef MWSB_STAMP_EN
  logic [2:0]  stamp_idx;
  logic [9:0]  stamp_v [2];
`endif

  logic [1:0]  busy_v, done_v, pass_v, fail_v, tout_v;
  logic [3:0]  mc_v [2];
  logic [9:0]  cc_v [2];
  logic [31:0] fa_v [2];
  logic [31:0] fd_v [2];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          sel;
    logic        pass;
    logic        fail;
    logic        tout;
    logic [3:0]  mc;
    logic [9:0]  cc;
    logic [31:0] fa;
    logic [31:0] fd;
  } exp_t;
  exp_t sb[$];

  logic [31:0] tab_a [8];
  logic [31:0] tab_d [8];

  always #5 clk = ~clk;

  mem_write_scoreboard #(.AW(32), .DW(32), .WE_W(2), .DEPTH(8), .CNT_W(10), .STRICT(0)) u_dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
    .load_data(load_data), .num_expect(num_expect), .timeout_lim(timeout_lim), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .tout(tout_v[0]),
    .match_cnt(mc_v[0]), .cycle_cnt(cc_v[0]), .fail_addr(fa_v[0]), .fail_data(fd_v[0])
`ifdef MWSB_STAMP_EN
    , .stamp_idx(stamp_idx), .stamp(stamp_v[0])
`endif
  );

  mem_write_scoreboard #(.AW(32), .DW(32), .WE_W(2), .DEPTH(8), .CNT_W(10), .STRICT(1)) u_dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
    .load_data(load_data), .num_expect(num_expect), .timeout_lim(timeout_lim), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .tout(tout_v[1]),
    .match_cnt(mc_v[1]), .cycle_cnt(cc_v[1]), .fail_addr(fa_v[1]), .fail_data(fd_v[1])
`ifdef MWSB_STAMP_EN
    , .stamp_idx(stamp_idx), .stamp(stamp_v[1])
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_idx = 3'(idx); load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic arm(input int sel, input logic [3:0] num, input logic [9:0] lim, input exp_t e);
    num_expect = num; timeout_lim = lim; start = 1'b1;
    if (sel >= 0) sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 2'b01; dataadr = a; writedata = d;
    tick();
    memwrite = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_done(input int sel, input int budget);
    exp_t e;
    int n = 0;
    while (!done_v[sel] && n < budget) begin
      tick();
      n++;
    end
    check("wait_done", done_v[sel], 1'b1);
    check("sb_nonempty", (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("pass", pass_v[e.sel], e.pass);
      check("fail", fail_v[e.sel], e.fail);
      check("tout", tout_v[e.sel], e.tout);
      check("busy_off", busy_v[e.sel], 1'b0);
      check("match_cnt", mc_v[e.sel], e.mc);
      check("cycle_cnt", cc_v[e.sel], e.cc);
      check("fail_addr", fa_v[e.sel], e.fa);
      check("fail_data", fd_v[e.sel], e.fd);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; load_en = 1'b0; load_idx = '0; load_addr = '0; load_data = '0;
    num_expect = '0; timeout_lim = '0; start = 1'b0; memwrite = '0; dataadr = '0; writedata = '0;
`ifdef MWSB_STAMP_EN
    stamp_idx = '0;
`endif
    #2;
    check("rst_busy", busy_v, 2'b00);
    check("rst_done", done_v, 2'b00);
    check("rst_mc", mc_v[0], 4'd0);
    check("rst_cc", cc_v[0], 10'd0);
    tick();
    reset = 1'b1;

    // In-order pass with an ignored non-matching store
    load(0, 32'd84, 32'd7);
    e = '{sel: 0, pass: 1, fail: 0, tout: 0, mc: 4'd1, cc: 10'd7, fa: 0, fd: 0};
    arm(0, 4'd1, 10'd32, e);
    idle(3);
    store(32'd80, 32'd5);
    idle(2);
    check("t1_busy_before", busy_v[0], 1'b1);
    store(32'd84, 32'd7);
    wait_done(0, 0);
    idle(3);
    check("t1_cc_frozen", cc_v[0], 10'd7);

    // Timeout exactly 32 cycles after start
    do_reset();
    load(0, 32'd84, 32'd7);
    e = '{sel: 0, pass: 0, fail: 0, tout: 1, mc: 4'd0, cc: 10'd32, fa: 0, fd: 0};
    arm(0, 4'd1, 10'd32, e);
    idle(31);
    check("t2_tout_early", tout_v[0], 1'b0);
    check("t2_busy_early", busy_v[0], 1'b1);
    tick();
    check("t2_tout_edge", tout_v[0], 1'b1);
    wait_done(0, 0);

    // Strict mismatch on the second store
    do_reset();
    load(0, 32'd0, 32'd1);
    load(1, 32'd4, 32'd2);
    e = '{sel: 1, pass: 0, fail: 1, tout: 0, mc: 4'd1, cc: 10'd2, fa: 32'd4, fd: 32'd3};
    arm(1, 4'd2, 10'd0, e);
    store(32'd0, 32'd1);
    store(32'd4, 32'd3);
    wait_done(1, 4);
    check("t3_lax_running", busy_v[0], 1'b1);

    // Full table with interleaved non-matching stores; num_expect 12 clamps to 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tab_a[i] = 32'h100 + 32'(i * 4);
      tab_d[i] = $urandom;
      load(i, tab_a[i], tab_d[i]);
    end
    e = '{sel: 0, pass: 1, fail: 0, tout: 0, mc: 4'd8, cc: 10'd24, fa: 0, fd: 0};
    arm(0, 4'd12, 10'd0, e);
    for (int i = 0; i < 8; i++) begin
      store(tab_a[i] + 32'd1, tab_d[i]);
      idle(1);
      store(tab_a[i], tab_d[i]);
    end
    wait_done(0, 4);

    // num_expect = 0 passes the cycle after start
    do_reset();
    e = '{sel: 0, pass: 1, fail: 0, tout: 0, mc: 4'd0, cc: 10'd0, fa: 0, fd: 0};
    arm(0, 4'd0, 10'd10, e);
    wait_done(0, 0);

    // Final match on the timeout cycle wins over timeout
    do_reset();
    load(0, 32'd84, 32'd7);
    e = '{sel: 1, pass: 1, fail: 0, tout: 0, mc: 4'd1, cc: 10'd5, fa: 0, fd: 0};
    arm(1, 4'd1, 10'd5, e);
    idle(4);
    store(32'd84, 32'd7);
    wait_done(1, 0);
    check("t6_lax_pass", pass_v[0], 1'b1);
    check("t6_lax_tout", tout_v[0], 1'b0);

    // Reset mid-RUN clears outputs without waiting for a clock edge
    do_reset();
    load(0, 32'd84, 32'd7);
    load(1, 32'd88, 32'd9);
    arm(-1, 4'd2, 10'd0, e);
    idle(2);
    store(32'd84, 32'd7);
    check("t7_mc_pre", mc_v[0], 4'd1);
    check("t7_busy_pre", busy_v[0], 1'b1);
    reset = 1'b0;
    #2;
    check("t7_busy_async", busy_v, 2'b00);
    check("t7_mc_async", mc_v[0], 4'd0);
    check("t7_cc_async", cc_v[0], 10'd0);
    check("t7_done_async", done_v, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef MWSB_STAMP_EN
    // Entry 0 matched at RUN cycle 5 stamps 5; a new start clears it
    do_reset();
    load(0, 32'd84, 32'd7);
    arm(-1, 4'd1, 10'd0, e);
    idle(5);
    store(32'd84, 32'd7);
    stamp_idx = 3'd0;
    #1;
    check("stamp_hit", stamp_v[0], 10'd5);
    arm(-1, 4'd1, 10'd0, e);
    check("stamp_clear", stamp_v[0], 10'd0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
